// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter.
//   word_t      : one data/address word
//   ramstate_t  : status reported by the single-port RAM
//   arb_state_t : arbiter FSM state (2-bit encoding, also exported on the debug port)
package mem_arb_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: puts the instruction-side and data-side cache requests onto a
// single-port RAM bus, one transaction at a time.
//
// Ports
//   CLK, nRST            clock (rising edge), synchronous active-high reset
//   iREN, iaddr          instruction read request and address
//   iwait, iload         instruction handshake: iwait=0 only in the completion cycle,
//                        iload carries the read data in that cycle and is 0 otherwise
//   dREN, dWEN, daddr,   data read/write request, address and write value
//   dstore
//   dwait, dload         data handshake: same rules as iwait/iload (dload=0 on writes)
//   ramREN, ramWEN,      RAM bus command
//   ramaddr, ramstore
//   ramload, ramstate    RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   ram_err              sticky: RAM reported ERROR during a granted access
//   timeout_err          sticky: a granted access was abandoned after TIMEOUT cycles
//   dbg_state            current FSM state (arb_state_t encoding)
//   dbg_streak           consecutive data grants since the last instruction grant
//
// Handshake: a side's request must stay high until its wait drops; the transfer
// happens in the single cycle where the side is granted and ramstate==ACCESS. A
// request dropped before that cycle cancels the transaction with no completion.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64,
  localparam int SW          = $clog2(MAX_D_STREAK + 1),
  localparam int TCW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ram_err,
  output logic              timeout_err,
  output logic [1:0]        dbg_state,
  output logic [SW-1:0]     dbg_streak
);

  arb_state_t     state_q, state_d;
  logic [SW-1:0]  streak_q, streak_d;
  logic [TCW-1:0] tcount_q, tcount_d;
  logic           ram_err_q, ram_err_d;
  logic           timeout_err_q, timeout_err_d;

  logic d_req;
  logic streak_full;
  logic ram_access;
  logic ram_error;
  logic tcount_last;

  assign d_req       = dREN | dWEN;
  assign streak_full = (streak_q == SW'(MAX_D_STREAK));
  assign ram_access  = (ramstate_t'(ramstate) == ACCESS);
  assign ram_error   = (ramstate_t'(ramstate) == ERROR);
  assign tcount_last = (tcount_q == TCW'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    tcount_d      = tcount_q;
    ram_err_d     = ram_err_q;
    timeout_err_d = timeout_err_q;

    iwait    = 1'b1;
    iload    = '0;
    dwait    = 1'b1;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    case (state_q)
      IDLE: begin
        // Data wins unless the instruction side has already been passed over
        // MAX_D_STREAK times in a row.
        if (d_req && !(iREN && streak_full)) begin
          state_d  = DGRANT;
          streak_d = streak_full ? streak_q : streak_q + SW'(1);
          tcount_d = '0;
        end else if (iREN) begin
          state_d  = IGRANT;
          streak_d = '0;
          tcount_d = '0;
        end
      end

      DGRANT: begin
        ramaddr = daddr;
        if (!d_req) begin
          // Request withdrawn: enables follow the live request, so the bus goes quiet.
          state_d = IDLE;
        end else begin
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (ram_access) begin
            dwait   = 1'b0;
            dload   = dWEN ? '0 : ramload;
            state_d = IDLE;
          end else begin
            if (ram_error) ram_err_d = 1'b1;
            if (tcount_last) begin
              timeout_err_d = 1'b1;
              state_d       = IDLE;
            end else begin
              tcount_d = tcount_q + TCW'(1);
            end
          end
        end
      end

      IGRANT: begin
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN = 1'b1;
          if (ram_access) begin
            iwait   = 1'b0;
            iload   = ramload;
            state_d = IDLE;
          end else begin
            if (ram_error) ram_err_d = 1'b1;
            if (tcount_last) begin
              timeout_err_d = 1'b1;
              state_d       = IDLE;
            end else begin
              tcount_d = tcount_q + TCW'(1);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q       <= IDLE;
      streak_q      <= '0;
      tcount_q      <= '0;
      ram_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      tcount_q      <= tcount_d;
      ram_err_q     <= ram_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ram_err     = ram_err_q;
  assign timeout_err = timeout_err_q;
  assign dbg_state   = state_q;
  assign dbg_streak  = streak_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter (MAX_D_STREAK=4, TIMEOUT=8).
// Inputs change 1 time unit after each rising edge; outputs are checked 2 units later.
module tb_memory_arbiter;
  import mem_arb_pkg::*;

  localparam int W = 32;

  logic          CLK;
  logic          nRST;
  logic          iREN;
  logic [W-1:0]  iaddr;
  logic          iwait;
  logic [W-1:0]  iload;
  logic          dREN;
  logic          dWEN;
  logic [W-1:0]  daddr;
  logic [W-1:0]  dstore;
  logic          dwait;
  logic [W-1:0]  dload;
  logic          ramREN;
  logic          ramWEN;
  logic [W-1:0]  ramaddr;
  logic [W-1:0]  ramstore;
  logic [W-1:0]  ramload;
  logic [1:0]    ramstate;
  logic          ram_err;
  logic          timeout_err;
  logic [1:0]    dbg_state;
  logic [2:0]    dbg_streak;

  int n_checks = 0;
  int n_fail   = 0;

  memory_arbiter #(.WORD_W(W), .MAX_D_STREAK(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .ram_err(ram_err), .timeout_err(timeout_err),
    .dbg_state(dbg_state), .dbg_streak(dbg_streak)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    iREN = 0; iaddr = '0; dREN = 0; dWEN = 0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
  endtask

  task automatic do_reset();
    nRST = 1'b1;
    tick();
    tick();
    nRST = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b1;
    tick();
    tick();
    #2;
    n_checks++; if (iwait !== 1'b1)   begin n_fail++; $display("FAIL reset_iwait: got %0b want 1", iwait); end
    n_checks++; if (dwait !== 1'b1)   begin n_fail++; $display("FAIL reset_dwait: got %0b want 1", dwait); end
    n_checks++; if ({ramREN, ramWEN} !== 2'b00) begin n_fail++; $display("FAIL reset_en: got %b want 00", {ramREN, ramWEN}); end
    n_checks++; if ({ram_err, timeout_err} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", {ram_err, timeout_err}); end
    n_checks++; if (iload !== 32'h0 || dload !== 32'h0) begin n_fail++; $display("FAIL reset_load: got %h %h want 0 0", iload, dload); end
    n_checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin n_fail++; $display("FAIL reset_bus: got %h %h want 0 0", ramaddr, ramstore); end
    nRST = 1'b0;
    tick();
    #2;
    n_checks++; if (dbg_state !== 2'(IDLE) || iwait !== 1'b1 || dwait !== 1'b1 || ramREN !== 1'b0)
      begin n_fail++; $display("FAIL idle_after_reset: state %0d iwait %0b dwait %0b ramREN %0b want 0 1 1 0", dbg_state, iwait, dwait, ramREN); end
  endtask

  task automatic test_single_read();
    iREN = 1; iaddr = 32'h40; ramstate = FREE;
    #2;
    n_checks++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin n_fail++; $display("FAIL read_grant_cycle: iwait %0b ramREN %0b want 1 0", iwait, ramREN); end
    tick();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #2;
    n_checks++; if (iwait !== 1'b0)   begin n_fail++; $display("FAIL read_iwait: got %0b want 0", iwait); end
    n_checks++; if (iload !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_iload: got %h want deadbeef", iload); end
    n_checks++; if (ramaddr !== 32'h40 || ramREN !== 1'b1 || ramWEN !== 1'b0) begin n_fail++; $display("FAIL read_bus: addr %h REN %0b WEN %0b want 40 1 0", ramaddr, ramREN, ramWEN); end
    n_checks++; if (dwait !== 1'b1)   begin n_fail++; $display("FAIL read_dwait: got %0b want 1", dwait); end
    tick();
    #2;
    n_checks++; if (dbg_state !== 2'(IDLE) || iwait !== 1'b1 || iload !== 32'h0 || ramREN !== 1'b0)
      begin n_fail++; $display("FAIL read_bubble: state %0d iwait %0b iload %h REN %0b want 0 1 0 0", dbg_state, iwait, iload, ramREN); end
    idle_inputs();
    tick();
  endtask

  task automatic test_write();
    // dREN and dWEN together: the write wins.
    dWEN = 1; dREN = 1; daddr = 32'h100; dstore = 32'h12345678; ramstate = BUSY;
    tick();
    #2;
    n_checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin n_fail++; $display("FAIL write_en: WEN %0b REN %0b want 1 0", ramWEN, ramREN); end
    n_checks++; if (ramstore !== 32'h12345678 || ramaddr !== 32'h100) begin n_fail++; $display("FAIL write_bus: store %h addr %h want 12345678 100", ramstore, ramaddr); end
    n_checks++; if (dwait !== 1'b1) begin n_fail++; $display("FAIL write_busy_dwait: got %0b want 1", dwait); end
    ramstate = ACCESS; ramload = 32'hAAAA5555;
    #2;
    n_checks++; if (dwait !== 1'b0 || dload !== 32'h0 || iwait !== 1'b1)
      begin n_fail++; $display("FAIL write_done: dwait %0b dload %h iwait %0b want 0 0 1", dwait, dload, iwait); end
    tick();
    idle_inputs();
    #2;
    n_checks++; if (dbg_state !== 2'(IDLE)) begin n_fail++; $display("FAIL write_bubble: state %0d want 0", dbg_state); end
    tick();
  endtask

  task automatic test_starvation();
    do_reset();
    iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h200;
    ramstate = ACCESS; ramload = 32'h0BADF00D;
    for (int k = 0; k < 15; k++) begin
      #2;
      n_checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin n_fail++; $display("FAIL starve_bubble_%0d: iwait %0b dwait %0b want 1 1", k, iwait, dwait); end
      tick();
      #2;
      if ((k % 5) != 4) begin
        n_checks++; if (dwait !== 1'b0 || iwait !== 1'b1 || ramaddr !== 32'h200 || dload !== 32'h0BADF00D)
          begin n_fail++; $display("FAIL starve_data_%0d: dwait %0b iwait %0b addr %h dload %h want 0 1 200 0badf00d", k, dwait, iwait, ramaddr, dload); end
      end else begin
        n_checks++; if (iwait !== 1'b0 || dwait !== 1'b1 || ramaddr !== 32'h80 || iload !== 32'h0BADF00D)
          begin n_fail++; $display("FAIL starve_instr_%0d: iwait %0b dwait %0b addr %h iload %h want 0 1 80 0badf00d", k, iwait, dwait, ramaddr, iload); end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_error_retry();
    do_reset();
    dREN = 1; daddr = 32'h300; ramstate = FREE;
    tick();
    ramstate = ERROR;
    for (int e = 0; e < 3; e++) begin
      #2;
      n_checks++; if (dwait !== 1'b1 || ramREN !== 1'b1 || dbg_state !== 2'(DGRANT))
        begin n_fail++; $display("FAIL err_retry_%0d: dwait %0b REN %0b state %0d want 1 1 1", e, dwait, ramREN, dbg_state); end
      tick();
    end
    ramstate = ACCESS; ramload = 32'hCAFEF00D;
    #2;
    n_checks++; if (ram_err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %0b want 1", ram_err); end
    n_checks++; if (dwait !== 1'b0 || dload !== 32'hCAFEF00D) begin n_fail++; $display("FAIL err_complete: dwait %0b dload %h want 0 cafef00d", dwait, dload); end
    tick();
    idle_inputs();
    tick();
    #2;
    n_checks++; if (ram_err !== 1'b1 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL err_sticky: ram_err %0b timeout_err %0b want 1 0", ram_err, timeout_err); end
  endtask

  task automatic test_timeout();
    do_reset();
    dREN = 1; daddr = 32'h400; ramstate = BUSY;
    tick();
    for (int g = 0; g < 8; g++) begin
      #2;
      n_checks++; if (dwait !== 1'b1 || dbg_state !== 2'(DGRANT) || timeout_err !== 1'b0)
        begin n_fail++; $display("FAIL timeout_wait_%0d: dwait %0b state %0d terr %0b want 1 1 0", g, dwait, dbg_state, timeout_err); end
      tick();
    end
    #2;
    n_checks++; if (dbg_state !== 2'(IDLE) || timeout_err !== 1'b1 || dwait !== 1'b1)
      begin n_fail++; $display("FAIL timeout_abort: state %0d terr %0b dwait %0b want 0 1 1", dbg_state, timeout_err, dwait); end
    n_checks++; if (ram_err !== 1'b0) begin n_fail++; $display("FAIL timeout_ram_err: got %0b want 0", ram_err); end
    idle_inputs();
    tick();
  endtask

  task automatic test_withdraw();
    dREN = 1; daddr = 32'h500; ramstate = BUSY;
    tick();
    dREN = 0;
    #2;
    n_checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b1)
      begin n_fail++; $display("FAIL withdraw_bus: REN %0b WEN %0b dwait %0b want 0 0 1", ramREN, ramWEN, dwait); end
    tick();
    #2;
    n_checks++; if (dbg_state !== 2'(IDLE)) begin n_fail++; $display("FAIL withdraw_state: got %0d want 0", dbg_state); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    // timeout_err is still set from the timeout scenario.
    dWEN = 1; daddr = 32'h600; dstore = 32'h55AA55AA; ramstate = ERROR;
    tick();
    tick();
    nRST = 1'b1;
    #2;
    n_checks++; if (ram_err !== 1'b1 || timeout_err !== 1'b1 || ramWEN !== 1'b1)
      begin n_fail++; $display("FAIL mid_pre: ram_err %0b terr %0b WEN %0b want 1 1 1", ram_err, timeout_err, ramWEN); end
    tick();
    nRST = 1'b0;
    #2;
    n_checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b1)
      begin n_fail++; $display("FAIL mid_bus: REN %0b WEN %0b dwait %0b want 0 0 1", ramREN, ramWEN, dwait); end
    n_checks++; if (dbg_streak !== 3'd0 || dbg_state !== 2'(IDLE))
      begin n_fail++; $display("FAIL mid_state: streak %0d state %0d want 0 0", dbg_streak, dbg_state); end
    n_checks++; if (ram_err !== 1'b0 || timeout_err !== 1'b0)
      begin n_fail++; $display("FAIL mid_flags: ram_err %0b terr %0b want 0 0", ram_err, timeout_err); end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    nRST = 1'b1;
    test_reset();
    test_single_read();
    test_write();
    test_starvation();
    test_error_retry();
    test_timeout();
    test_withdraw();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
